// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared feeder state enum and load-slice struct for the tensor core feeders
package tensor_core_pkg;
  localparam int SLICE_N = 16;
  localparam int SLICE_W = 32;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} feeder_state_t;
  typedef struct packed {
    logic [SLICE_N-1:0][SLICE_W-1:0] act;
    logic [SLICE_N-1:0][SLICE_W-1:0] wgt;
  } slice_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: load-slice handshake and skewed array-edge outputs of systolic_feeder
interface systolic_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  logic in_valid;
  logic in_ready;
  logic signed [DATA_W-1:0] in_act [ROWS];
  logic signed [DATA_W-1:0] in_wgt [COLS];
  logic signed [DATA_W-1:0] act_data [ROWS];
  logic [ROWS-1:0] act_valid;
  logic signed [DATA_W-1:0] wgt_data [COLS];
  logic [COLS-1:0] wgt_valid;
  logic counter_sync_out;
  logic tile_done;
  modport master (
    output in_valid, in_act, in_wgt,
    input in_ready, act_data, act_valid, wgt_data, wgt_valid, counter_sync_out, tile_done
  );
  modport slave (
    input in_valid, in_act, in_wgt,
    output in_ready, act_data, act_valid, wgt_data, wgt_valid, counter_sync_out, tile_done
  );
endinterface

// File: rtl/feeder_tile_buf.sv
// feeder_tile_buf: K-slot tile bank written by beat index and read along the skew diagonal
module feeder_tile_buf import tensor_core_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int K = 8,
  parameter int TW = 4
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(K)-1:0] waddr,
  input  slice_t wdata,
  input  logic en,
  input  logic [TW-1:0] rt,
  output logic [ROWS-1:0][DATA_W-1:0] act,
  output logic [ROWS-1:0] act_v,
  output logic [COLS-1:0][DATA_W-1:0] wgt,
  output logic [COLS-1:0] wgt_v
);
  localparam int BW = $clog2(K);
  logic [ROWS-1:0][DATA_W-1:0] mem_act [K];
  logic [COLS-1:0][DATA_W-1:0] mem_wgt [K];
  logic unused_bits;
  assign unused_bits = ^wdata;
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < ROWS; i++) mem_act[waddr][i] <= wdata.act[i][DATA_W-1:0];
      for (int j = 0; j < COLS; j++) mem_wgt[waddr][j] <= wdata.wgt[j][DATA_W-1:0];
    end
  end
  always_comb begin
    act = '0;
    act_v = '0;
    wgt = '0;
    wgt_v = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (en && int'(rt) >= i && int'(rt) - i < K) begin
        act_v[i] = 1'b1;
        act[i] = mem_act[BW'(int'(rt) - i)][i];
      end
    end
    for (int j = 0; j < COLS; j++) begin
      if (en && int'(rt) >= j && int'(rt) - j < K) begin
        wgt_v[j] = 1'b1;
        wgt[j] = mem_wgt[BW'(int'(rt) - j)][j];
      end
    end
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers K load slices and streams them diagonally skewed to the array edge; SYSTOLIC_FEEDER_DOUBLE_BUF_EN adds a shadow bank
module systolic_feeder import tensor_core_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int K = 8
) (
  input logic clk,
  input logic reset,
  systolic_feeder_if.slave bus
);
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int S = K + (ROWS > COLS ? ROWS : COLS) - 1;
  localparam int BW = $clog2(K);
  localparam int TW = $clog2(S + 1);
  localparam logic [BW-1:0] K_LAST = BW'(K - 1);
  localparam logic [TW-1:0] T_LAST = TW'(S - 1);
  localparam logic DBUF = NB == 2;
  feeder_state_t state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [TW-1:0] t, t_n, rd_t;
  logic wsel, wsel_n, rsel, rsel_n, full, full_n;
  logic accept, last_beat, last_t, start, rd_en, rd_sel;
  slice_t wdata;
  logic [ROWS-1:0][DATA_W-1:0] bank_act [NB];
  logic [COLS-1:0][DATA_W-1:0] bank_wgt [NB];
  logic [ROWS-1:0] bank_av [NB];
  logic [COLS-1:0] bank_wv [NB];
  assign bus.in_ready = !reset && (state != STREAM || (DBUF && !full));
  assign accept = bus.in_valid && bus.in_ready;
  assign last_beat = accept && bcnt == K_LAST;
  assign last_t = state == STREAM && t == T_LAST;
  assign start = (last_beat && state != STREAM) || (last_t && (full || last_beat));
  assign rd_en = start || (state == STREAM && !last_t);
  assign rd_t = start ? '0 : t + TW'(1);
  assign rd_sel = start ? wsel : rsel;
  always_comb begin
    state_n = state;
    bcnt_n = accept ? (last_beat ? '0 : bcnt + BW'(1)) : bcnt;
    t_n = t;
    wsel_n = wsel;
    rsel_n = rsel;
    full_n = full;
    if (start) begin
      state_n = STREAM;
      t_n = '0;
      rsel_n = wsel;
      wsel_n = wsel ^ DBUF;
      full_n = 1'b0;
    end else if (last_t) begin
      state_n = bcnt_n != '0 ? LOAD : IDLE;
    end else if (state == STREAM) begin
      t_n = t + TW'(1);
      full_n = full || last_beat;
    end else if (accept) begin
      state_n = LOAD;
    end
  end
  always_comb begin
    wdata = '0;
    for (int i = 0; i < ROWS; i++) wdata.act[i][DATA_W-1:0] = bus.in_act[i];
    for (int j = 0; j < COLS; j++) wdata.wgt[j][DATA_W-1:0] = bus.in_wgt[j];
  end
  for (genvar b = 0; b < NB; b++) begin : g_bank
    feeder_tile_buf #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .K(K), .TW(TW)) u_buf (
      .clk(clk),
      .we(accept && wsel == 1'(b)),
      .waddr(bcnt),
      .wdata(wdata),
      .en(rd_en),
      .rt(rd_t),
      .act(bank_act[b]),
      .act_v(bank_av[b]),
      .wgt(bank_wgt[b]),
      .wgt_v(bank_wv[b])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcnt <= '0;
      t <= '0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      full <= 1'b0;
      bus.act_valid <= '0;
      bus.wgt_valid <= '0;
      bus.counter_sync_out <= 1'b0;
      bus.tile_done <= 1'b0;
      for (int i = 0; i < ROWS; i++) bus.act_data[i] <= '0;
      for (int j = 0; j < COLS; j++) bus.wgt_data[j] <= '0;
    end else begin
      state <= state_n;
      bcnt <= bcnt_n;
      t <= t_n;
      wsel <= wsel_n;
      rsel <= rsel_n;
      full <= full_n;
      bus.act_valid <= rd_sel ? bank_av[NB-1] : bank_av[0];
      bus.wgt_valid <= rd_sel ? bank_wv[NB-1] : bank_wv[0];
      bus.counter_sync_out <= start;
      bus.tile_done <= last_t;
      for (int i = 0; i < ROWS; i++) bus.act_data[i] <= rd_sel ? bank_act[NB-1][i] : bank_act[0][i];
      for (int j = 0; j < COLS; j++) bus.wgt_data[j] <= rd_sel ? bank_wgt[NB-1][j] : bank_wgt[0][j];
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench for systolic_feeder at ROWS=COLS=K=4, DATA_W=8 (SYSTOLIC_FEEDER_DOUBLE_BUF_EN adds the overlap case)
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int N = 4;
  localparam int S = 7;
  typedef struct packed {
    logic [N-1:0][DW-1:0] act;
    logic [N-1:0] av;
    logic [N-1:0][DW-1:0] wgt;
    logic [N-1:0] wv;
    logic sync;
    logic done;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rec_t sb[$];
  rec_t e;
  logic [N-1:0][DW-1:0] ga, gw;
  logic [N-1:0][DW-1:0] cur_a [N];
  logic [N-1:0][DW-1:0] cur_w [N];
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  systolic_feeder_if #(.DATA_W(DW), .ROWS(N), .COLS(N)) bus ();
  systolic_feeder #(.DATA_W(DW), .ROWS(N), .COLS(N), .K(N)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push_tile(input bit overlap);
    rec_t r;
    for (int t = 0; t < S; t++) begin
      r = '0;
      r.sync = (t == 0);
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          r.act[i] = cur_a[t-i][i];
          r.av[i] = 1'b1;
          r.wgt[i] = cur_w[t-i][i];
          r.wv[i] = 1'b1;
        end
      end
      if (overlap && t == 0) begin
        r.done = 1'b1;
        sb[sb.size()-1] = r;
      end else sb.push_back(r);
    end
    r = '0;
    r.done = 1'b1;
    sb.push_back(r);
  endtask
  task automatic rand_tile();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        cur_a[k][i] = 8'($urandom);
        cur_w[k][i] = 8'($urandom);
      end
  endtask
  task automatic load_tile(input bit toggle, input bit lat);
    for (int k = 0; k < N; k++) begin
      int w = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.in_act[i] = cur_a[k][i];
        bus.in_wgt[i] = cur_w[k][i];
      end
      while (!bus.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) chk("ready_timeout", bus.in_ready, 1);
      @(posedge clk);
      if (toggle && k < N - 1) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
          bus.in_act[i] = 8'($urandom);
          bus.in_wgt[i] = 8'($urandom);
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (lat) begin
      chk("t0_sync", bus.counter_sync_out, 1);
`ifndef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
      chk("stream_ready", bus.in_ready, 0);
`endif
    end
  endtask
  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (!reset && (bus.counter_sync_out || bus.tile_done || |bus.act_valid || |bus.wgt_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {bus.counter_sync_out, bus.tile_done, bus.act_valid, bus.wgt_valid}, 0);
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          ga[i] = bus.act_data[i];
          gw[i] = bus.wgt_data[i];
        end
        chk("act_data", ga, e.act);
        chk("act_valid", bus.act_valid, e.av);
        chk("wgt_data", gw, e.wgt);
        chk("wgt_valid", bus.wgt_valid, e.wv);
        chk("counter_sync", bus.counter_sync_out, e.sync);
        chk("tile_done", bus.tile_done, e.done);
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.in_act[i] = '0;
      bus.in_wgt[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ga[i] = bus.act_data[i];
      gw[i] = bus.wgt_data[i];
    end
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_act_valid", bus.act_valid, 0);
    chk("rst_wgt_valid", bus.wgt_valid, 0);
    chk("rst_act_data", ga, 0);
    chk("rst_wgt_data", gw, 0);
    chk("rst_sync", bus.counter_sync_out, 0);
    chk("rst_done", bus.tile_done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        cur_a[k][i] = 8'(k + 1);
        cur_w[k][i] = 8'(k + 1);
      end
    push_tile(0);
    load_tile(0, 1);
    drain();
    rand_tile();
    push_tile(0);
    load_tile(1, 1);
    drain();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        cur_a[k][i] = ((k + i) % 2 == 1) ? 8'h80 : 8'h7F;
        cur_w[k][i] = ((k + i) % 2 == 1) ? 8'h7F : 8'h80;
      end
    push_tile(0);
    load_tile(0, 1);
    drain();
    repeat (2) begin
      rand_tile();
      push_tile(0);
      load_tile(0, 1);
      drain();
    end
    rand_tile();
    push_tile(0);
    load_tile(0, 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < N; i++) begin
      ga[i] = bus.act_data[i];
      gw[i] = bus.wgt_data[i];
    end
    chk("abort_act_valid", bus.act_valid, 0);
    chk("abort_wgt_valid", bus.wgt_valid, 0);
    chk("abort_act_data", ga, 0);
    chk("abort_wgt_data", gw, 0);
    chk("abort_sync", bus.counter_sync_out, 0);
    chk("abort_done", bus.tile_done, 0);
    chk("abort_ready", bus.in_ready, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("release_ready", bus.in_ready, 1);
    repeat (8) begin
      @(negedge clk);
      chk("abort_no_done", bus.tile_done, 0);
    end
    rand_tile();
    push_tile(0);
    load_tile(0, 1);
    drain();
`ifdef SYSTOLIC_FEEDER_DOUBLE_BUF_EN
    rand_tile();
    push_tile(0);
    load_tile(0, 1);
    rand_tile();
    push_tile(1);
    load_tile(0, 0);
    drain();
`endif
    chk("final_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning element width of activations and weights.
REQ-002 SHALL have parameter ROWS, default 8, meaning number of PE rows fed with activations.
REQ-003 SHALL have parameter COLS, default 8, meaning number of PE columns fed with weights.
REQ-004 SHALL have parameter K, default 8, meaning reduction depth: slices per tile.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, meaning a load slice is presented.
REQ-008 SHALL have port in_ready, output, 1, meaning the slice is accepted this cycle when in_valid is high.
REQ-009 SHALL have port in_act, input, signed DATA_W x [ROWS], meaning activation column k of tile A.
REQ-010 SHALL have port in_wgt, input, signed DATA_W x [COLS], meaning weight row k of tile B.
REQ-011 SHALL have port act_data, output, signed DATA_W x [ROWS], meaning the per-row activation into the array edge.
REQ-012 SHALL have port act_valid, output, 1 x [ROWS], meaning the per-row activation valid.
REQ-013 SHALL have port wgt_data, output, signed DATA_W x [COLS], meaning the per-column weight into the array edge.
REQ-014 SHALL have port wgt_valid, output, 1 x [COLS], meaning the per-column weight valid.
REQ-015 SHALL have port counter_sync_out, output, 1, a one-cycle pulse that drives the array's MAC counter sync input.
REQ-016 SHALL have port tile_done, output, 1, a one-cycle pulse at the end of a tile stream.

Function
REQ-017 SHALL implement states IDLE, LOAD, STREAM: IDLE->LOAD on the first accepted beat, LOAD->STREAM after the K-th accepted beat, STREAM->IDLE after the last stream cycle.
REQ-018 SHALL hold in_ready at 1 in IDLE and LOAD, and at 0 in STREAM (see REQ-030 for the exception).
REQ-019 SHALL store accepted beat n (0..K-1) into buffer slot n; a beat counter counts 0..K-1 and wraps to 0 on tile completion.
REQ-020 SHALL stream for S = K + max(ROWS,COLS) - 1 output cycles, indexed by stream counter t = 0..S-1.
REQ-021 SHALL, in output cycle t, drive act_valid[i]=1 and act_data[i]=slot[t-i].act[i] when 0 <= t-i < K, and otherwise act_valid[i]=0 and act_data[i]=0.
REQ-022 SHALL apply the same diagonal skew to the weights: wgt_valid[j]=1 and wgt_data[j]=slot[t-j].wgt[j] when 0 <= t-j < K, and otherwise 0.
REQ-023 SHALL register all array-edge outputs; output cycle t=0 is the cycle after the K-th beat is accepted.
REQ-024 SHALL pulse counter_sync_out in output cycle t=0 only.
REQ-025 SHALL pulse tile_done in the cycle after output cycle t=S-1, with all valids 0 in that cycle.
REQ-026 SHALL ignore in_act and in_wgt when in_valid=0 or in_ready=0; no slot or counter changes in those cycles.
REQ-027 SHALL pass data through unmodified, with no arithmetic and no width change.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, beat and stream counters to 0, every output data and valid to 0, counter_sync_out=0, tile_done=0 and in_ready=0.
REQ-029 SHALL treat reset asserted mid-LOAD or mid-STREAM as an abort: partial tile discarded, no tile_done, and in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with macro SYSTOLIC_FEEDER_DOUBLE_BUF_EN defined, instantiate two buffer banks: in_ready=1 during STREAM while the shadow bank is not full, and when the shadow bank is full at t=S-1 the next tile's t=0 (with counter_sync_out) follows immediately, in the same cycle as tile_done, with no bubble.
REQ-031 SHALL, without SYSTOLIC_FEEDER_DOUBLE_BUF_EN, have a single bank and behave exactly as REQ-017..REQ-026.

Structure
REQ-032 SHALL take the feeder state enum and the slice struct (act and wgt vectors) from the shared package tensor_core_pkg.
REQ-033 SHALL place slot storage in one sub-module, feeder_tile_buf (K-entry write-indexed, skew-indexed read bank), instantiated once or twice per REQ-030/031.

Verification (ROWS=COLS=K=4, DATA_W=8)
REQ-034 SHALL verify: load slices act=wgt={k+1} for k=0..3 -> row0 outputs 1,2,3,4 in t=0..3; row3 outputs 1..4 in t=3..6; S=7; tile_done one cycle after t=6.
REQ-035 SHALL verify: in_valid toggled 1,0,1,0... during LOAD -> exactly 4 beats stored, and the stream starts the cycle after the 4th accepted beat.
REQ-036 SHALL verify: counter_sync_out high only at t=0; act_valid[2] low at t=0,1 and t=6 with act_data[2]=0.
REQ-037 SHALL verify: reset asserted at t=2 -> all outputs 0 the next cycle, no tile_done, and in_ready=1 after release.
REQ-038 SHALL verify, under DOUBLE_BUF_EN: second tile loaded during the first stream -> second t=0 coincides with the first tile_done, with zero idle cycles.
REQ-039 SHALL verify: negative values (-128, 127) pass through bit-exact on both act and wgt paths.
